frodo_gearbox_64to448: RTL

Write-side width converter for the Frodo datapath. It accepts 64-bit words one at a time from the SHAKE squeeze port or the 64-bit RAMs and assembles 448-bit beats (28 × 16-bit coefficients) for RAM448 or the MAC array. It is the 64→448 counterpart of the 448→64 read path. Matrix rows of n coefficients (640/976/1344) do not divide evenly into 448-bit beats, so the block tracks row boundaries and zero-pads the final beat of each row.

---
 rtl/frodo_pkg.sv | 45 ++++
 rtl/gearbox_ctrl.sv | 92 +++++++++
 rtl/frodo_gearbox_64to448.sv | 123 ++++++++++++
 3 files changed

// File: rtl/frodo_pkg.sv
// Shared constants for the Frodo 64->448 write-side gearbox: security-level
// encoding, per-level row geometry and the controller state encoding.
package frodo_pkg;

    // sec_lvl encoding; the reserved code behaves like the 640 level
    localparam logic [1:0] SEC_640  = 2'd0;
    localparam logic [1:0] SEC_976  = 2'd1;
    localparam logic [1:0] SEC_1344 = 2'd2;
    localparam logic [1:0] SEC_RSVD = 2'd3;

    // 64-bit words in one matrix row (n * 16 / 64) and words in its last beat
    localparam int WORDS_PER_ROW   [3] = '{160, 244, 336};
    localparam int LAST_BEAT_WORDS [3] = '{6, 6, 7};

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Fold the reserved level onto the 640 level
    function automatic logic [1:0] norm_sec(input logic [1:0] s);
        return (s == SEC_RSVD) ? SEC_640 : s;
    endfunction

    // Words per row for a (normalised) level
    function automatic logic [8:0] words_per_row(input logic [1:0] s);
        case (s)
            SEC_976:  return 9'(WORDS_PER_ROW[1]);
            SEC_1344: return 9'(WORDS_PER_ROW[2]);
            default:  return 9'(WORDS_PER_ROW[0]);
        endcase
    endfunction

    // Word mask of the final (possibly short) beat of a row
    function automatic logic [6:0] last_beat_mask(input logic [1:0] s);
        int n;
        case (s)
            SEC_976:  n = LAST_BEAT_WORDS[1];
            SEC_1344: n = LAST_BEAT_WORDS[2];
            default:  n = LAST_BEAT_WORDS[0];
        endcase
        return 7'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/gearbox_ctrl.sv
// Gearbox controller: IDLE/RUN/DRAIN FSM plus word-in-beat, word-in-row and
// row counters. Produces the beat-completion and row-end strobes for the
// current input word, the frame-start strobe and the done pulse.
module gearbox_ctrl
    import frodo_pkg::*;
#(
    parameter int WORDS_PER_BEAT = 7,
    parameter int ROW_W          = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       sec_lvl,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             in_fire,     // input word accepted this cycle
    input  logic             out_fire,    // output beat handshaked this cycle
    output logic [1:0]       state,       // FSM state, visible for debug
    output logic [2:0]       wcnt,
    output logic [1:0]       sec_q,       // latched, normalised level
    output logic             beat_done,   // current word completes a beat
    output logic             row_end,     // current word is last of its row
    output logic             frame_start, // accepted start of a non-empty or empty frame
    output logic             done
);

    logic [8:0]       rwcnt;
    logic [ROW_W-1:0] rcnt;
    logic [ROW_W-1:0] rows_q;
    logic [8:0]       wpr;
    logic             last_row;

    assign frame_start = (state == ST_IDLE) && start;
    assign wpr         = words_per_row(sec_q);
    assign row_end     = (rwcnt == wpr - 9'd1);
    assign beat_done   = (wcnt == 3'(WORDS_PER_BEAT - 1)) || row_end;
    assign last_row    = (rcnt == rows_q - ROW_W'(1));

    // Frame FSM and done pulse; done is high the cycle after the final beat
    // handshakes, or the cycle after a start with zero rows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_rows == '0) done  <= 1'b1;
                        else                state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_fire && row_end && last_row) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame parameters latch and the three position counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sec_q  <= SEC_640;
            rows_q <= '0;
            wcnt   <= '0;
            rwcnt  <= '0;
            rcnt   <= '0;
        end else if (frame_start) begin
            sec_q  <= norm_sec(sec_lvl);
            rows_q <= num_rows;
            wcnt   <= '0;
            rwcnt  <= '0;
            rcnt   <= '0;
        end else if (in_fire) begin
            wcnt <= beat_done ? 3'd0 : wcnt + 3'd1;
            if (row_end) begin
                rwcnt <= '0;
                rcnt  <= rcnt + ROW_W'(1);
            end else begin
                rwcnt <= rwcnt + 9'd1;
            end
        end
    end

endmodule

// File: rtl/frodo_gearbox_64to448.sv
// Frodo 64->448 write-side width converter. Collects 64-bit words into
// 448-bit beats, zero-padding the short final beat of each matrix row.
// Handshake: a transfer happens on a side when its val and rdy are both high
// at the rising edge; out_val/out_data hold until out_rdy, and in_rdy only
// drops for a beat-completing word while the previous beat is still pending.
module frodo_gearbox_64to448
    import frodo_pkg::*;
#(
    parameter int WORDS_PER_BEAT = 7,
    parameter int ROW_W          = 11
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [1:0]                   sec_lvl,
    input  logic                         start,
    input  logic [ROW_W-1:0]             num_rows,
    input  logic [63:0]                  in_data,
    input  logic                         in_val,
    output logic                         in_rdy,
    output logic [WORDS_PER_BEAT*64-1:0] out_data,
    output logic [WORDS_PER_BEAT-1:0]    out_wmask,
    output logic                         out_row_end,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [ROW_W-1:0]             row_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int BEAT_W = WORDS_PER_BEAT * 64;

    logic [1:0]                state;
    logic [2:0]                wcnt;
    logic [1:0]                sec_q;
    logic                      beat_done;
    logic                      row_end;
    logic                      frame_start;
    logic                      in_fire;
    logic                      out_fire;
    logic [BEAT_W-1:0]         asm_q;
    logic [BEAT_W-1:0]         beat_next;
    logic [WORDS_PER_BEAT-1:0] mask_next;

    assign busy     = (state != ST_IDLE);
    assign in_rdy   = (state == ST_RUN) && (!beat_done || !out_val || out_rdy);
    assign in_fire  = in_val && in_rdy;
    assign out_fire = out_val && out_rdy;

    gearbox_ctrl #(
        .WORDS_PER_BEAT(WORDS_PER_BEAT),
        .ROW_W         (ROW_W)
    ) u_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .sec_lvl    (sec_lvl),
        .num_rows   (num_rows),
        .in_fire    (in_fire),
        .out_fire   (out_fire),
        .state      (state),
        .wcnt       (wcnt),
        .sec_q      (sec_q),
        .beat_done  (beat_done),
        .row_end    (row_end),
        .frame_start(frame_start),
        .done       (done)
    );

    // Beat image if the current word completes: stored words, then the
    // incoming word in slot wcnt, zeros above it.
    always_comb begin
        beat_next = '0;
        for (int k = 0; k < WORDS_PER_BEAT; k++) begin
            if (3'(k) < wcnt)       beat_next[k*64 +: 64] = asm_q[k*64 +: 64];
            else if (3'(k) == wcnt) beat_next[k*64 +: 64] = in_data;
        end
        mask_next = row_end ? last_beat_mask(sec_q) : '1;
    end

    // Assembly register: store non-completing words, clear on completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_q <= '0;
        end else if (in_fire) begin
            if (beat_done) begin
                asm_q <= '0;
            end else begin
                for (int k = 0; k < WORDS_PER_BEAT; k++) begin
                    if (3'(k) == wcnt) asm_q[k*64 +: 64] <= in_data;
                end
            end
        end
    end

    // Output beat register; a completing word loads it, out_rdy drains it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_val     <= 1'b0;
            out_data    <= '0;
            out_wmask   <= '0;
            out_row_end <= 1'b0;
        end else if (in_fire && beat_done) begin
            out_val     <= 1'b1;
            out_data    <= beat_next;
            out_wmask   <= mask_next;
            out_row_end <= row_end;
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

    // Rows fully emitted; cleared by any accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt <= '0;
        end else if (frame_start) begin
            row_cnt <= '0;
        end else if (out_fire && out_row_end) begin
            row_cnt <= row_cnt + ROW_W'(1);
        end
    end

endmodule
